// File: rtl/seq_alu_pkg.sv
// Shared types and sizing helpers for the sequential slice-based ALU paths.
package seq_alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int SLICE_W   = 8;
  localparam int DEF_WIDTH = 32;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

  // Keep at least one index bit so a single-slice build still has a counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_SLICES = num_slices(DEF_WIDTH);
  localparam int DEF_IDX_W      = idx_width(DEF_NUM_SLICES);

endpackage

// File: rtl/sub_slice_8bit.sv
// Combinational SLICE_W-bit adder with carry in/out; shared by every RUN cycle.
module sub_slice_8bit
  import seq_alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/seq_sub_32bit.sv
// Multi-cycle subtractor: one SLICE_W slice per clock, LSB first, registered carry.
// Optional add/subtract select on port op_sub when SEQ_SUB_ADD_MODE_EN is defined.
module seq_sub_32bit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
`ifdef SEQ_SUB_ADD_MODE_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int NUM_SLICES = num_slices(WIDTH);
  localparam int IDX_W      = idx_width(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
`ifdef SEQ_SUB_ADD_MODE_EN
  logic             sub_q, sub_d;
`endif

  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] s_slice;
  logic               c_slice;

  assign a_slice = a_q[idx_q*SLICE_W +: SLICE_W];
  assign b_slice = b_q[idx_q*SLICE_W +: SLICE_W];

  sub_slice_8bit u_slice (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .sum  (s_slice),
    .cout (c_slice)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    diff_d     = diff_q;
    done_d     = done_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
`ifdef SEQ_SUB_ADD_MODE_EN
    sub_d      = sub_q;
`endif

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          a_d     = in1;
`ifdef SEQ_SUB_ADD_MODE_EN
          sub_d   = op_sub;
          b_d     = op_sub ? ~in2 : in2;
          carry_d = op_sub;
`else
          b_d     = ~in2;
          carry_d = 1'b1;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        diff_d[idx_q*SLICE_W +: SLICE_W] = s_slice;
        carry_d = c_slice;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
`ifdef SEQ_SUB_ADD_MODE_EN
          borrow_d = sub_q ? ~c_slice : c_slice;
`else
          borrow_d = ~c_slice;
`endif
          // b_q already holds ~in2 for subtract, so one sign rule covers both modes.
          overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (s_slice[SLICE_W-1] != a_q[WIDTH-1]);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      done_q     <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SEQ_SUB_ADD_MODE_EN
      sub_q      <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      diff_q     <= diff_d;
      done_q     <= done_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
`ifdef SEQ_SUB_ADD_MODE_EN
      sub_q      <= sub_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_sub_32bit.sv
// Directed bench for seq_sub_32bit with an arithmetic reference model and per-cycle compare.
module tb_seq_sub_32bit;

  localparam int WIDTH = 32;
  localparam int NS    = WIDTH / 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             op_sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic chk_en  = 1'b0;

  always #5 clock = ~clock;

  seq_sub_32bit #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
`ifdef SEQ_SUB_ADD_MODE_EN
    .op_sub   (op_sub),
`endif
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Reference: {borrow, overflow, diff} straight from integer arithmetic.
  function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                         input logic sub);
    longint sx, sy, r;
    logic [32:0] u;
    logic [31:0] d;
    logic brw, ovf;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sub) begin
      d   = x - y;
      brw = (x < y);
      r   = sx - sy;
    end else begin
      u   = {1'b0, x} + {1'b0, y};
      d   = u[31:0];
      brw = u[32];
      r   = sx + sy;
    end
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {brw, ovf, d};
  endfunction

  logic        op_sub_eff;
`ifdef SEQ_SUB_ADD_MODE_EN
  assign op_sub_eff = op_sub;
`else
  assign op_sub_eff = 1'b1;
`endif

  logic        m_busy, m_done, m_borrow, m_ovf, p_borrow, p_ovf;
  logic [31:0] m_diff, p_diff;
  int          m_cnt;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_diff <= '0;
      m_borrow <= 1'b0; m_ovf <= 1'b0; m_cnt <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        {p_borrow, p_ovf, p_diff} <= ref_op(in1, in2, op_sub_eff);
      end
    end else if (m_cnt == NS) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b1;
      m_diff   <= p_diff;
      m_borrow <= p_borrow;
      m_ovf    <= p_ovf;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      if (!m_busy) begin
        check("cyc_diff", diff, m_diff);
        check("cyc_borrow", borrow, m_borrow);
        check("cyc_overflow", overflow, m_ovf);
      end
    end
  end

  // Call just after an accepting edge has passed; counts edges until done is seen.
  task automatic wait_done(output int lat);
    lat = 21;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] ed,
                              input logic eb, input logic eo);
    check({name, "_diff"}, diff, ed);
    check({name, "_borrow"}, borrow, eb);
    check({name, "_overflow"}, overflow, eo);
  endtask

  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ed, input logic eb, input logic eo);
    int lat;
    @(negedge clock);
    in1 = x; in2 = y; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    wait_done(lat);
    check({name, "_latency"}, lat, NS);
    check_result(name, ed, eb, eo);
  endtask

  initial begin
    int lat;
    logic seen;
    reset_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0; op_sub = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_result("rst", 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    run_op("sub_5_3", 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);
    run_op("sub_0_1", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("sub_min_1", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Start held through RUN with other operands; only the done-cycle start counts.
    @(negedge clock);
    in1 = 32'h0000_0100; in2 = 32'h0000_0001; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in1 = 32'hDEAD_0000; in2 = 32'h0000_BEEF;
    wait_done(lat);
    check("b2b_first_latency", lat, NS);
    check_result("b2b_first", 32'h0000_00FF, 1'b0, 1'b0);
    @(negedge clock);
    in1 = 32'h0000_0010; in2 = 32'h0000_0020;
    @(posedge clock);
    #1;
    check("b2b_accept_busy", busy, 1'b1);
    check("b2b_accept_done", done, 1'b0);
    @(negedge clock);
    start = 1'b0;
    wait_done(lat);
    check("b2b_spacing", lat + 1, NS + 1);
    check_result("b2b_second", 32'hFFFF_FFF0, 1'b1, 1'b0);

    // Reset asserted for the second RUN edge.
    @(negedge clock);
    in1 = 32'h0000_FFFF; in2 = 32'h0000_0001; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check_result("midrst", 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 1'b0);
    run_op("after_rst", 32'h1234_5678, 32'h0234_5679, 32'h0FFF_FFFF, 1'b0, 1'b0);

`ifdef SEQ_SUB_ADD_MODE_EN
    op_sub = 1'b0;
    run_op("add_max_1", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    op_sub = 1'b1;
    run_op("sub_again", 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0);
`endif

    repeat (3) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
